// File: rtl/shift_pkg.sv
// Shared constants for the sequential right-shift unit: mode codes and FSM states.
package shift_pkg;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_RRC = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_right_step.sv
// One single-bit right-shift step; the mode only decides what enters the MSB.
module shift_right_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] w,
    input  logic             c,
    output logic [WIDTH-1:0] w_next,
    output logic             c_next
);

    logic msb;

    always_comb begin
        msb = 1'b0;
        case (mode)
            MODE_LSR: msb = 1'b0;
            MODE_ROR: msb = w[0];
            MODE_RRC: msb = c;
            MODE_ASR: msb = w[WIDTH-1];
            default:  msb = 1'b0;
        endcase
    end

    assign w_next = {msb, w[WIDTH-1:1]};
    assign c_next = w[0];

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter: start/busy/done handshake, one bit position per clock.
module shift_right_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] x,
    input  logic [SHW-1:0]   amount,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout
);

    state_t           state, state_n;
    logic [SHW-1:0]   cnt;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] w, w_step;
    logic             c, c_step;
    logic             load, step;

    shift_right_step #(.WIDTH(WIDTH)) u_step (
        .mode   (mode_q),
        .w      (w),
        .c      (c),
        .w_next (w_step),
        .c_next (c_step)
    );

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        case (state)
            IDLE: if (start) begin
                load    = 1'b1;
                state_n = SHIFT;
            end
            SHIFT: begin
                if (cnt != '0) step = 1'b1;
                else           state_n = DONE;
            end
            // DONE accepts a new request directly so back-to-back ops have no bubble
            DONE: begin
                load    = start;
                state_n = start ? SHIFT : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= MODE_LSR;
            w      <= '0;
            c      <= 1'b0;
        end else begin
            state <= state_n;
            if (load) begin
                w      <= x;
                c      <= cin;
                cnt    <= amount;
                mode_q <= mode;
            end else if (step) begin
                w   <= w_step;
                c   <= c_step;
                cnt <= cnt - SHW'(1);
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign f    = w;
    assign cout = c;

endmodule
